// File: rtl/music_pkg.sv
// Shared constants and types for the tone generator / tone meter audio path.
// Duty words are scaled so that DUTY_FULL means 100 %.
package music_pkg;

   localparam int DUTY_FULL  = 1024;
   localparam int DUTY_MAX   = 1023;
   localparam int DEF_CLK_HZ = 100_000_000;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      DIV_F,
      DIV_D,
      REPORT
   } tm_state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; start reloads at any time.
// done is high on the W-th cycle after start, and quotient is valid in that same cycle.
module seq_divider #(
   parameter int W = 42
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient
);

   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  r_rem;
   logic [W-1:0]  r_quo;
   logic [W-1:0]  r_div;
   logic [CW-1:0] r_cnt;
   logic [W:0]    w_trial;
   logic [W:0]    w_diff;

   // Bit W of the difference is set exactly when the trial remainder is below the divisor.
   assign w_trial = {r_rem, r_quo[W-1]};
   assign w_diff  = w_trial - {1'b0, r_div};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem <= '0;
         r_quo <= '0;
         r_div <= '0;
         r_cnt <= '0;
      end else if (start) begin
         r_rem <= '0;
         r_quo <= dividend;
         r_div <= divisor;
         r_cnt <= CW'(W);
      end else if (r_cnt != '0) begin
         if (!w_diff[W]) begin
            r_rem <= w_diff[W-1:0];
            r_quo <= {r_quo[W-2:0], 1'b1};
         end else begin
            r_rem <= w_trial[W-1:0];
            r_quo <= {r_quo[W-2:0], 1'b0};
         end
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign busy     = (r_cnt != '0);
   assign done     = (r_cnt == CW'(1));
   assign quotient = {r_quo[W-2:0], ~w_diff[W]};

endmodule

// File: rtl/tone_meter.sv
// Measures period and high time of pwm_in between rises; reports Hz and 1024-scaled duty
// 2*DW+1 cycles after the completing rise, or a zero-frequency report after TIMEOUT_CYC of silence.
module tone_meter
   import music_pkg::*;
#(
   parameter int CLK_HZ      = DEF_CLK_HZ,
   parameter int CNT_W       = 32,
   parameter int TIMEOUT_CYC = 100_000_000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] freq,
   output logic [9:0]       duty,
   output logic             valid,
   output logic             no_signal
);

   localparam int               DUTY_SH      = $clog2(DUTY_FULL);
   localparam int               DW           = CNT_W + DUTY_SH;
   localparam logic [CNT_W-1:0] TO_CNT       = CNT_W'(TIMEOUT_CYC);
   localparam logic [DW-1:0]    CLK_DIVIDEND = DW'(CLK_HZ);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_prev;
   logic             w_rise;
   logic [CNT_W-1:0] r_per;
   logic [CNT_W-1:0] r_hi;
   logic [CNT_W-1:0] r_p;
   logic [CNT_W-1:0] r_h;
   tm_state_t        r_state;
   tm_state_t        w_next;
   logic             w_timeout;
   logic             w_div_start;
   logic [DW-1:0]    w_div_dividend;
   logic [DW-1:0]    w_div_divisor;
   logic [DW-1:0]    w_quo;
   logic             w_div_busy;
   logic             w_div_done;
   logic [CNT_W-1:0] r_freq_q;
   logic [CNT_W-1:0] r_freq;
   logic [9:0]       r_duty;
   logic [9:0]       w_duty_sat;
   logic             r_nosig;
   logic             r_to_vld;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= pwm_in;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_rise = r_sync2 & ~r_prev;

   // per_cnt during a rise cycle equals the distance to the previous rise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_per <= '0;
         r_hi  <= '0;
      end else if (w_rise) begin
         r_per <= CNT_W'(1);
         r_hi  <= CNT_W'(r_sync2);
      end else begin
         if (r_per < TO_CNT)
            r_per <= r_per + 1'b1;
         if (r_sync2 && (r_hi < TO_CNT))
            r_hi <= r_hi + 1'b1;
      end
   end

   assign w_timeout = (r_per == TO_CNT) && (r_state != IDLE) && !w_rise;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_timeout) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE:   if (w_rise) w_next = ARMED;
            ARMED:  if (w_rise) w_next = DIV_F;
            DIV_F: begin
               if (w_div_done)       w_next = DIV_D;
               else if (!w_div_busy) w_next = ARMED;
            end
            DIV_D: begin
               if (w_div_done)       w_next = REPORT;
               else if (!w_div_busy) w_next = ARMED;
            end
            REPORT: w_next = ARMED;
            default: w_next = IDLE;
         endcase
      end
   end

   always_comb begin
      w_div_start    = 1'b0;
      w_div_dividend = CLK_DIVIDEND;
      w_div_divisor  = DW'(r_per);
      if ((r_state == ARMED) && w_rise) begin
         w_div_start = 1'b1;
      end else if ((r_state == DIV_F) && w_div_done && !w_timeout) begin
         w_div_start    = 1'b1;
         w_div_dividend = {r_h, {DUTY_SH{1'b0}}};
         w_div_divisor  = DW'(r_p);
      end
   end

   assign valid = (r_state == REPORT) | r_to_vld;

   seq_divider #(
      .W(DW)
   ) u_div (
      .clk      (clk),
      .rst_n    (reset),
      .start    (w_div_start),
      .dividend (w_div_dividend),
      .divisor  (w_div_divisor),
      .busy     (w_div_busy),
      .done     (w_div_done),
      .quotient (w_quo)
   );

   assign w_duty_sat = (w_quo > DW'(DUTY_MAX)) ? 10'(DUTY_MAX) : w_quo[9:0];

   // Results are staged so freq and duty only move in the cycle valid is high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_p      <= '0;
         r_h      <= '0;
         r_freq_q <= '0;
         r_freq   <= '0;
         r_duty   <= '0;
         r_nosig  <= 1'b1;
         r_to_vld <= 1'b0;
      end else begin
         r_to_vld <= 1'b0;
         if ((r_state == ARMED) && w_rise) begin
            r_p <= r_per;
            r_h <= r_hi;
         end
         if ((r_state == DIV_F) && w_div_done)
            r_freq_q <= w_quo[CNT_W-1:0];
         if (w_timeout) begin
            r_freq   <= '0;
            r_duty   <= r_sync2 ? 10'(DUTY_MAX) : 10'd0;
            r_nosig  <= 1'b1;
            r_to_vld <= 1'b1;
         end else if ((r_state == DIV_D) && w_div_done) begin
            r_freq  <= r_freq_q;
            r_duty  <= w_duty_sat;
            r_nosig <= 1'b0;
         end
      end
   end

   assign freq      = r_freq;
   assign duty      = r_duty;
   assign no_signal = r_nosig;

endmodule

// File: tb/tb_tone_meter.sv
// Directed bench for tone_meter with a period/high-time reference model checked every cycle.
// Scaled clock (1 MHz) keeps the tone scenarios short while exercising the same arithmetic.
module tb_tone_meter;

   localparam int CLK_HZ      = 1_000_000;
   localparam int CNT_W       = 32;
   localparam int TIMEOUT_CYC = 5000;
   localparam int LAT         = 2 * (CNT_W + 10) + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             pwm_in;
   logic [CNT_W-1:0] freq;
   logic [9:0]       duty;
   logic             valid;
   logic             no_signal;

   int total = 0;
   int bad   = 0;

   // reference model state
   longint cyc = 0;
   bit     m_cur, m_s1, m_s2, m_s3;
   bit     seen;
   longint last_rise, hcnt;
   bit     rpt_pend, to_pend;
   longint rpt_cyc, to_cyc, pf, pd, td, sched_rise;
   longint exp_freq, exp_duty;
   bit     exp_vld, exp_nosig;

   // observation of the DUT
   longint n_vld = 0;
   longint last_vld_cyc = -1;
   longint gap_prev = -1;
   longint min_gap = 1_000_000_000;
   longint base;

   tone_meter #(
      .CLK_HZ      (CLK_HZ),
      .CNT_W       (CNT_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pwm_in    (pwm_in),
      .freq      (freq),
      .duty      (duty),
      .valid     (valid),
      .no_signal (no_signal)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      bit rise;
      bit in_rpt;
      longint p;
      cyc++;
      if (reset === 1'b0) begin
         m_cur = 0; m_s1 = 0; m_s2 = 0; m_s3 = 0;
         seen = 0; rpt_pend = 0; to_pend = 0; hcnt = 0;
         exp_vld = 0; exp_freq = 0; exp_duty = 0; exp_nosig = 1;
      end else begin
         m_s3 = m_s2; m_s2 = m_s1; m_s1 = m_cur; m_cur = pwm_in;
         rise   = m_s2 && !m_s3;
         exp_vld = 0;
         in_rpt  = 0;
         if (rpt_pend && cyc == rpt_cyc) begin
            exp_vld = 1; exp_freq = pf; exp_duty = pd; exp_nosig = 0;
            rpt_pend = 0; in_rpt = 1;
         end
         if (to_pend && cyc == to_cyc) begin
            exp_vld = 1; exp_freq = 0; exp_duty = td; exp_nosig = 1;
            to_pend = 0;
         end
         if (rise) begin
            if (!seen) begin
               seen = 1;
            end else if (!rpt_pend && !in_rpt) begin
               p  = cyc - last_rise;
               pf = CLK_HZ / p;
               pd = (hcnt * 1024) / p;
               if (pd > 1023) pd = 1023;
               rpt_pend = 1; rpt_cyc = cyc + LAT; sched_rise = cyc;
            end
            last_rise = cyc;
            hcnt = 1;
         end else begin
            hcnt += m_s2;
            if (seen && (cyc - last_rise == TIMEOUT_CYC)) begin
               seen = 0; rpt_pend = 0;
               to_pend = 1; to_cyc = cyc + 1;
               td = m_s2 ? 1023 : 0;
            end
         end
      end
      check("valid", valid, exp_vld);
      check("freq", freq, exp_freq);
      check("duty", duty, exp_duty);
      check("no_signal", no_signal, exp_nosig);
      if (valid === 1'b1) begin
         n_vld++;
         if (gap_prev >= 0 && (cyc - gap_prev) < min_gap) min_gap = cyc - gap_prev;
         gap_prev = cyc;
         last_vld_cyc = cyc;
      end
   end

   task automatic hold(input logic v, input int n);
      pwm_in = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wave(input int p, input int h, input int n);
      for (int k = 0; k < n; k++) begin
         hold(1'b1, h);
         hold(1'b0, p - h);
      end
   endtask

   initial begin
      reset  = 1'b0;
      pwm_in = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("rst_freq", freq, 0);
      check("rst_duty", duty, 0);
      check("rst_valid", valid, 0);
      check("rst_no_signal", no_signal, 1);
      reset = 1'b1;

      // 500 Hz, 50 %
      base = n_vld;
      wave(2000, 1000, 3);
      check("p500_reports", n_vld - base, 2);
      check("p500_freq", freq, 500);
      check("p500_duty", duty, 512);
      check("p500_no_signal", no_signal, 0);
      check("p500_model_freq", exp_freq, 500);
      check("p500_latency", last_vld_cyc - sched_rise, 85);

      // 1 kHz, 25 %
      base = n_vld;
      wave(1000, 250, 4);
      check("p1k_reports", n_vld - base, 4);
      check("p1k_freq", freq, 1000);
      check("p1k_duty", duty, 256);
      check("p1k_model_duty", exp_duty, 256);

      // input stops low
      base = n_vld;
      hold(1'b0, 4100);
      check("tolow_reports", n_vld - base, 1);
      check("tolow_freq", freq, 0);
      check("tolow_duty", duty, 0);
      check("tolow_no_signal", no_signal, 1);
      check("tolow_latency", last_vld_cyc - last_rise, TIMEOUT_CYC + 1);

      // input stuck high
      base = n_vld;
      wave(1000, 500, 2);
      hold(1'b1, 5200);
      check("tohigh_reports", n_vld - base, 3);
      check("tohigh_freq", freq, 0);
      check("tohigh_duty", duty, 1023);
      check("tohigh_no_signal", no_signal, 1);

      // reset while the duty division is running
      base = n_vld;
      hold(1'b0, 10);
      wave(1000, 500, 1);
      hold(1'b1, 60);
      reset = 1'b0;
      hold(1'b1, 3);
      check("midrst_reports", n_vld - base, 0);
      check("midrst_duty", duty, 0);
      check("midrst_no_signal", no_signal, 1);
      reset = 1'b1;
      wave(1000, 300, 3);
      check("postrst_reports", n_vld - base, 2);
      check("postrst_freq", freq, 1000);
      check("postrst_duty", duty, 307);

      // periods shorter than the report latency are sampled
      base = n_vld;
      gap_prev = -1;
      min_gap = 1_000_000_000;
      wave(20, 10, 40);
      check("short_reports", n_vld - base, 8);
      check("short_freq", freq, 50000);
      check("short_duty", duty, 512);
      check("short_min_gap", min_gap, 100);

      // rise coinciding with per_cnt reaching the timeout
      base = n_vld;
      wave(TIMEOUT_CYC, TIMEOUT_CYC / 2, 2);
      hold(1'b1, 200);
      check("coinc_reports", n_vld - base, 3);
      check("coinc_freq", freq, 200);
      check("coinc_duty", duty, 512);
      check("coinc_no_signal", no_signal, 0);
      base = n_vld;
      hold(1'b0, 6000);
      check("coinc_to_reports", n_vld - base, 1);
      check("coinc_to_no_signal", no_signal, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
